// File: rtl/iccm_port_arbiter.sv
// Arbitrates the single-port ICCM between instruction fetch and the UART boot programmer,
// and holds the core in reset for the programming session plus a fixed tail.
module iccm_port_arbiter #(
  parameter int unsigned AW         = 12,
  parameter int unsigned DW         = 32,
  parameter int unsigned FifoDepth  = 2,
  parameter int unsigned HoldCycles = 16
) (
  input  logic          clk_i,
  input  logic          reset,
  input  logic          f_req_i,
  input  logic [AW-1:0] f_addr_i,
  output logic          f_gnt_o,
  output logic          f_rvalid_o,
  output logic [DW-1:0] f_rdata_o,
  input  logic          p_we_i,
  input  logic [AW-1:0] p_addr_i,
  input  logic [DW-1:0] p_wdata_i,
  input  logic          p_done_i,
  output logic          m_req_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic [DW-1:0] m_rdata_i,
  output logic          core_hold_o,
  output logic          prog_busy_o,
  output logic          overflow_o
);

  localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned Slots = 1 << PtrW;
  localparam int unsigned CntW  = $clog2(FifoDepth + 1);
  localparam int unsigned HoldW = $clog2(HoldCycles + 1);

  typedef enum logic [1:0] {StIdle, StDrain, StProg, StRelease} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              rvalid_q, rvalid_d;
  logic [AW-1:0]     addr_q [Slots];
  logic [DW-1:0]     data_q [Slots];
  logic              full, empty, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full  = (count_q == CntW'(FifoDepth));
  assign empty = (count_q == '0);
  assign pop   = (state_q == StProg) && !empty;
  // A full FIFO still accepts a write when the head retires in the same cycle.
  assign push  = p_we_i && (!full || pop);

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    hold_d    = hold_q;
    rvalid_d  = 1'b0;
    f_gnt_o   = 1'b0;
    m_req_o   = 1'b0;
    m_we_o    = 1'b0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    unique case (state_q)
      StIdle: begin
        if (f_req_i && !reset) begin
          f_gnt_o  = 1'b1;
          m_req_o  = 1'b1;
          m_addr_o = f_addr_i;
          rvalid_d = 1'b1;
        end
        if (p_we_i) state_d = StDrain;
      end
      StDrain: begin
        if (p_done_i) done_d = 1'b1;
        state_d = StProg;
      end
      StProg: begin
        if (pop) begin
          m_req_o   = 1'b1;
          m_we_o    = 1'b1;
          m_addr_o  = addr_q[rd_ptr_q];
          m_wdata_o = data_q[rd_ptr_q];
        end
        if ((done_q || p_done_i) && empty && !p_we_i) begin
          state_d = StRelease;
          hold_d  = HoldW'(HoldCycles);
          done_d  = 1'b0;
        end else if (p_done_i) begin
          done_d = 1'b1;
        end
      end
      StRelease: begin
        // A late write restarts the session; done must be signalled again.
        if (p_we_i) begin
          state_d = StProg;
          done_d  = p_done_i;
        end else if (hold_q == HoldW'(1)) begin
          state_d = StIdle;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    ovf_d    = ovf_q | (p_we_i && full && !pop);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_ptr_q] <= p_addr_i;
      data_q[wr_ptr_q] <= p_wdata_i;
    end
  end

  assign f_rvalid_o  = rvalid_q;
  assign f_rdata_o   = rvalid_q ? m_rdata_i : '0;
  assign core_hold_o = (state_q != StIdle);
  assign prog_busy_o = (state_q != StIdle);
  assign overflow_o  = ovf_q;

endmodule
